// File: rtl/cv32e40s_dbg_trace_buf.sv
// cv32e40s_dbg_trace_buf: triggerable circular history of decode-stage info, frozen for indexed readout
module cv32e40s_dbg_trace_buf #(
  parameter int REGFILE_NUM_READ_PORTS = 2,
  parameter int DEPTH = 16,
  parameter int POST_TRIGGER = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int EW = 40 + 6 * REGFILE_NUM_READ_PORTS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              valid_i,
  input  logic [31:0]                       instr_i,
  input  logic                              is_compressed_i,
  input  logic [REGFILE_NUM_READ_PORTS-1:0] rf_re_i,
  input  logic [4:0]                        rf_raddr_i [REGFILE_NUM_READ_PORTS],
  input  logic                              rf_we_i,
  input  logic [4:0]                        rf_waddr_i,
  input  logic                              illegal_insn_i,
  input  logic                              clear_i,
  input  logic                              arm_i,
  input  logic [1:0]                        trig_mode_i,
  input  logic                              trig_i,
  input  logic [4:0]                        match_waddr_i,
  input  logic [6:0]                        match_opcode_i,
  input  logic [AW-1:0]                     rd_idx_i,
  output logic [EW-1:0]                     rd_entry_o,
  output logic [AW:0]                       count_o,
  output logic [1:0]                        state_o,
  output logic [AW-1:0]                     trig_idx_o
);
  typedef enum logic [1:0] {IDLE, ARMED, POST, FROZEN} state_t;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PT = AW'(POST_TRIGGER);
  localparam logic [AW-1:0] PT1 = AW'(POST_TRIGGER + 1);
  state_t state;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, post_cnt, wptr_nxt, oldest, rd_addr;
  logic [AW:0] count, count_nxt;
  logic [5*REGFILE_NUM_READ_PORTS-1:0] raddr_flat;
  logic [EW-1:0] entry;
  logic we, trig_hit, rd_hit;
  for (genvar g = 0; g < REGFILE_NUM_READ_PORTS; g++) begin : g_raddr
    assign raddr_flat[5*g +: 5] = rf_raddr_i[g];
  end
  assign entry = {instr_i, is_compressed_i, rf_re_i, raddr_flat, rf_we_i, rf_waddr_i, illegal_insn_i};
  always_comb begin
    we = valid_i && state != FROZEN && !clear_i;
    trig_hit = valid_i && (trig_mode_i == 2'd0 ? trig_i :
                           trig_mode_i == 2'd1 ? illegal_insn_i :
                           trig_mode_i == 2'd2 ? rf_we_i && rf_waddr_i == match_waddr_i :
                                                 instr_i[6:0] == match_opcode_i);
    wptr_nxt = we ? wptr + 1'b1 : wptr;
    count_nxt = we && count != DEPTH_C ? count + 1'b1 : count;
    oldest = count == DEPTH_C ? wptr : '0;
    rd_addr = oldest + rd_idx_i;
    rd_hit = {1'b0, rd_idx_i} < count;
  end
  always_ff @(posedge clk) if (we) mem[wptr] <= entry;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      wptr <= '0;
      post_cnt <= '0;
      rd_entry_o <= '0;
    end else begin
      rd_entry_o <= rd_hit ? mem[rd_addr] : '0;
      if (clear_i) begin
        state <= IDLE;
        count <= '0;
        wptr <= '0;
        post_cnt <= '0;
      end else if (arm_i) begin
        state <= ARMED;
        count <= state == FROZEN ? '0 : count_nxt;
        wptr <= state == FROZEN ? '0 : wptr_nxt;
      end else begin
        count <= count_nxt;
        wptr <= wptr_nxt;
        if (state == ARMED && trig_hit) begin
          state <= POST_TRIGGER == 0 ? FROZEN : POST;
          post_cnt <= PT;
        end else if (state == POST && valid_i) begin
          post_cnt <= post_cnt - 1'b1;
          if (post_cnt == AW'(1)) state <= FROZEN;
        end
      end
    end
  end
  assign count_o = count;
  assign state_o = state;
  assign trig_idx_o = state == FROZEN ? count[AW-1:0] - PT1 : '0;
endmodule

// File: tb/tb_cv32e40s_dbg_trace_buf.sv
// tb_cv32e40s_dbg_trace_buf: directed stimulus with queued expectations checked by a decoupled monitor
module tb_cv32e40s_dbg_trace_buf;
  logic clk = 0, rst = 1, valid = 0, is_c = 0, rf_we = 0, ill = 0, clear = 0, arm = 0, trig = 0;
  logic [31:0] instr = 0;
  logic [1:0] rf_re = 0, mode = 0, state;
  logic [4:0] rf_raddr [2];
  logic [4:0] rf_waddr = 0, match_waddr = 0;
  logic [6:0] match_opcode = 0;
  logic [3:0] rd_idx = 0, trig_idx;
  logic [51:0] rd_entry;
  logic [4:0] count;
  int cyc = 0, n_tests = 0, n_fail = 0;
  typedef struct {int kind; logic [63:0] exp; int due; string name;} exp_t;
  exp_t q[$];

  cv32e40s_dbg_trace_buf dut (
    .clk(clk), .rst(rst), .valid_i(valid), .instr_i(instr), .is_compressed_i(is_c),
    .rf_re_i(rf_re), .rf_raddr_i(rf_raddr), .rf_we_i(rf_we), .rf_waddr_i(rf_waddr),
    .illegal_insn_i(ill), .clear_i(clear), .arm_i(arm), .trig_mode_i(mode), .trig_i(trig),
    .match_waddr_i(match_waddr), .match_opcode_i(match_opcode), .rd_idx_i(rd_idx),
    .rd_entry_o(rd_entry), .count_o(count), .state_o(state), .trig_idx_o(trig_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, actual hang, required finish");
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    while (q.size() != 0 && q[0].due <= cyc) begin
      exp_t e;
      logic [63:0] act;
      e = q.pop_front();
      act = e.kind == 0 ? 64'(count) : e.kind == 1 ? 64'(state) : e.kind == 2 ? 64'(trig_idx) :
            e.kind == 3 ? 64'(rd_entry[51:20]) : e.kind == 4 ? 64'(rd_entry) : 64'(rd_entry[0]);
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: actual %0h required %0h", e.name, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input int kind, input logic [63:0] exp, input string name);
    q.push_back('{kind, exp, cyc, name});
  endtask
  task automatic wr(input logic [31:0] i, input logic il);
    valid = 1; instr = i; ill = il;
    step();
    valid = 0; ill = 0;
  endtask
  task automatic rd(input int idx);
    rd_idx = 4'(idx);
    step();
  endtask
  task automatic do_reset();
    rst = 1; arm = 0; clear = 0; valid = 0; rf_we = 0; rf_waddr = 0; trig = 0;
    step(); step();
    rst = 0;
  endtask

  initial begin
    rf_raddr[0] = 0; rf_raddr[1] = 0;
    rd_idx = 3;
    do_reset();
    chk(0, 0, "reset_count"); chk(1, 0, "reset_state"); chk(2, 0, "reset_trig_idx");
    rd(3); chk(4, 0, "empty_read_after_reset");
    valid = 1; instr = 32'hDEADBEEF; is_c = 1; rf_re = 2'b10; rf_raddr[1] = 3; rf_raddr[0] = 7;
    rf_we = 1; rf_waddr = 9; ill = 0;
    step();
    valid = 0; is_c = 0; rf_re = 0; rf_raddr[1] = 0; rf_raddr[0] = 0; rf_we = 0; rf_waddr = 0;
    chk(0, 1, "write_latency_count");
    wr(32'h33, 0); chk(0, 2, "two_writes_count");
    rd(0); chk(4, 52'hDEADBEEF_C33D2, "entry_packing");
    rd(2); chk(4, 0, "empty_read_past_count");
    rd(1); chk(3, 32'h33, "second_entry");
    do_reset();
    for (int k = 0; k < 20; k++) wr(32'h1000 + k, 0);
    chk(0, 16, "fill_count_saturates"); chk(1, 0, "fill_state_idle");
    rd(0); chk(3, 32'h1004, "fill_oldest");
    rd(15); chk(3, 32'h1013, "fill_newest");
    rd(5); chk(3, 32'h1009, "fill_mid");
    do_reset();
    mode = 1;
    wr(32'h2000, 0); wr(32'h2001, 1);
    chk(1, 0, "idle_ignores_trigger");
    arm = 1; step(); arm = 0;
    chk(1, 1, "armed"); chk(0, 2, "arm_keeps_contents");
    for (int j = 1; j <= 30; j++) begin
      wr(32'h3000 + j, j == 10);
      if (j == 9) chk(1, 1, "pre_trigger_armed");
      if (j == 10) chk(1, 2, "illegal_trigger_post");
      if (j == 13) chk(1, 2, "still_post");
      if (j == 14) chk(1, 3, "frozen_after_window");
    end
    chk(0, 16, "frozen_count"); chk(2, 11, "illegal_trig_idx");
    rd(11); chk(3, 32'h300A, "trig_entry_instr"); chk(5, 1, "trig_entry_illegal");
    rd(15); chk(3, 32'h300E, "frozen_newest");
    rd(0); chk(3, 32'h2000, "frozen_oldest");
    arm = 1; step(); arm = 0;
    chk(0, 0, "rearm_count"); chk(1, 1, "rearm_state"); chk(2, 0, "rearm_trig_idx");
    wr(32'h4444, 0);
    rd(0); chk(3, 32'h4444, "rearm_first_entry");
    mode = 0; trig = 1; arm = 1; valid = 1; instr = 32'h5555;
    step();
    valid = 0; arm = 0; trig = 0;
    chk(1, 1, "arm_beats_trigger"); chk(0, 2, "arm_cycle_still_writes");
    do_reset();
    mode = 2; match_waddr = 5;
    arm = 1; step(); arm = 0;
    rf_we = 1; rf_waddr = 4; wr(32'h10, 0);
    rf_we = 0; rf_waddr = 5; wr(32'h11, 0);
    chk(1, 1, "rdmatch_needs_we");
    rf_we = 1; rf_waddr = 5; wr(32'h12, 0);
    rf_we = 0; rf_waddr = 0;
    chk(1, 2, "rdmatch_trigger");
    for (int j = 0; j < 4; j++) wr(32'h20 + j, 0);
    chk(1, 3, "rdmatch_frozen"); chk(0, 7, "rdmatch_count"); chk(2, 2, "rdmatch_trig_idx");
    do_reset();
    mode = 3; match_opcode = 7'h73;
    arm = 1; step(); arm = 0;
    wr(32'h13, 0); chk(1, 1, "opcode_no_match");
    wr(32'h00100073, 0); chk(1, 2, "opcode_match");
    clear = 1; arm = 1; valid = 1; instr = 32'h77;
    step();
    clear = 0; arm = 0; valid = 0;
    chk(1, 0, "clear_priority_state"); chk(0, 0, "clear_priority_count");
    rd(0); chk(4, 0, "cleared_read_zero");
    step(); step();
    if (q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL pending_checks: actual %0d unchecked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
